rng_health_monitor: RTL and testbench

Consumer-side companion to the randomizer. It takes the randomizer's 2-bit output stream and runs continuous health tests on it: a repetition count test (RCT) and an adaptive proportion test (APT). Samples reach the downstream logic only after the source has passed a startup window. Any failure raises a sticky alarm and blocks the data stream until software clears it.

---
 rtl/rng_pkg.sv | 16 +
 rtl/rng_apt_window.sv | 62 ++++++
 rtl/rng_health_monitor.sv | 122 ++++++++++++
 tb/tb_rng_health_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and default parameters for the RNG health monitor.
// Symbol width matches the randomizer output; cutoffs size the RCT/APT counters.
package rng_pkg;

  localparam int SYM_W_DEF      = 2;
  localparam int RCT_CUTOFF_DEF = 8;
  localparam int APT_WINDOW_DEF = 64;
  localparam int APT_CUTOFF_DEF = 40;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    ALARM   = 2'd2
  } state_e;

endpackage

// File: rtl/rng_apt_window.sv
// Adaptive proportion test: counts the first symbol of each window; o_hit is a same-cycle pulse.
// No backpressure; state advances only on accepted samples, i_clear restarts the window.
module rng_apt_window
  import rng_pkg::*;
#(
  parameter int SYM_W      = SYM_W_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [SYM_W-1:0] i_r,
  output logic             o_hit,
  output logic             o_last
);

  localparam int IDX_W = $clog2(APT_WINDOW);
  localparam int CNT_W = $clog2(APT_CUTOFF + 1);

  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [SYM_W-1:0] ref_sym_q, ref_sym_d;
  logic [CNT_W-1:0] apt_cnt_q, apt_cnt_d;

  always_comb begin
    win_idx_d = win_idx_q;
    ref_sym_d = ref_sym_q;
    apt_cnt_d = apt_cnt_q;
    o_hit     = 1'b0;
    if (i_clear) begin
      win_idx_d = '0;
      ref_sym_d = '0;
      apt_cnt_d = '0;
    end else if (i_accept) begin
      // Window length is a power of two, so the index wraps on its own.
      win_idx_d = win_idx_q + IDX_W'(1);
      if (win_idx_q == '0) begin
        ref_sym_d = i_r;
        apt_cnt_d = CNT_W'(1);
      end else if ((i_r == ref_sym_q) && (apt_cnt_q != CNT_W'(APT_CUTOFF))) begin
        apt_cnt_d = apt_cnt_q + CNT_W'(1);
      end
      o_hit = (apt_cnt_d == CNT_W'(APT_CUTOFF));
    end
  end

  assign o_last = (win_idx_q == IDX_W'(APT_WINDOW - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_idx_q <= '0;
      ref_sym_q <= '0;
      apt_cnt_q <= '0;
    end else begin
      win_idx_q <= win_idx_d;
      ref_sym_q <= ref_sym_d;
      apt_cnt_q <= apt_cnt_d;
    end
  end

endmodule

// File: rtl/rng_health_monitor.sv
// RCT + APT health monitor gating the RNG stream; 1-cycle latency, forwards only in RUN.
// No backpressure: o_ready is status only; any failure latches ALARM and blocks data until i_clear.
module rng_health_monitor
  import rng_pkg::*;
#(
  parameter int SYM_W      = SYM_W_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [SYM_W-1:0] i_r,
  input  logic             i_clear,
  output logic             o_valid,
  output logic [SYM_W-1:0] o_r,
  output logic             o_ready,
  output logic             o_rct_fail,
  output logic             o_apt_fail,
  output logic             o_alarm
);

  localparam int REP_W = $clog2(RCT_CUTOFF + 1);

  state_e           state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [SYM_W-1:0] last_sym_q, last_sym_d;
  logic             first_q, first_d;
  logic             rct_fail_q, rct_fail_d;
  logic             apt_fail_q, apt_fail_d;
  logic             valid_q, valid_d;
  logic [SYM_W-1:0] r_q, r_d;

  logic accept, apt_hit, apt_last, rct_hit, fail_now;

  assign accept = i_valid & ~i_clear;

  rng_apt_window #(
    .SYM_W     (SYM_W),
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
  ) u_apt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_accept(accept),
    .i_r     (i_r),
    .o_hit   (apt_hit),
    .o_last  (apt_last)
  );

  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    last_sym_d = last_sym_q;
    first_d    = first_q;
    rct_fail_d = rct_fail_q;
    apt_fail_d = apt_fail_q;
    valid_d    = 1'b0;
    r_d        = r_q;
    rct_hit    = 1'b0;
    fail_now   = 1'b0;
    if (i_clear) begin
      state_d    = STARTUP;
      rep_cnt_d  = '0;
      first_d    = 1'b1;
      rct_fail_d = 1'b0;
      apt_fail_d = 1'b0;
    end else if (accept) begin
      r_d     = i_r;
      first_d = 1'b0;
      if (first_q || (i_r != last_sym_q)) begin
        rep_cnt_d  = REP_W'(1);
        last_sym_d = i_r;
      end else if (rep_cnt_q != REP_W'(RCT_CUTOFF)) begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
      rct_hit    = (rep_cnt_d == REP_W'(RCT_CUTOFF));
      fail_now   = rct_hit | apt_hit;
      rct_fail_d = rct_fail_q | rct_hit;
      apt_fail_d = apt_fail_q | apt_hit;
      valid_d    = (state_q == RUN) && !fail_now;
      // A failure on the last startup sample wins over entering RUN.
      if (fail_now) begin
        state_d = ALARM;
      end else if ((state_q == STARTUP) && apt_last) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= STARTUP;
      rep_cnt_q  <= '0;
      last_sym_q <= '0;
      first_q    <= 1'b1;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      valid_q    <= 1'b0;
      r_q        <= '0;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      last_sym_q <= last_sym_d;
      first_q    <= first_d;
      rct_fail_q <= rct_fail_d;
      apt_fail_q <= apt_fail_d;
      valid_q    <= valid_d;
      r_q        <= r_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_r        = r_q;
  assign o_ready    = (state_q == RUN);
  assign o_alarm    = (state_q == ALARM);
  assign o_rct_fail = rct_fail_q;
  assign o_apt_fail = apt_fail_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor with a sample-history reference model.
module tb_rng_health_monitor;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [1:0] i_r = 2'd0;
  logic       i_clear = 1'b0;
  logic       o_valid, o_ready, o_rct_fail, o_apt_fail, o_alarm;
  logic [1:0] o_r;

  rng_health_monitor dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_r       (i_r),
    .i_clear   (i_clear),
    .o_valid   (o_valid),
    .o_r       (o_r),
    .o_ready   (o_ready),
    .o_rct_fail(o_rct_fail),
    .o_apt_fail(o_apt_fail),
    .o_alarm   (o_alarm)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: every accepted symbol since reset/clear, re-scanned per sample.
  logic [1:0] hist[$];
  bit         m_rct, m_apt, m_passed;
  logic       exp_valid, exp_ready, exp_alarm, exp_rct, exp_apt;
  logic [1:0] exp_r;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_publish();
    exp_rct   = m_rct;
    exp_apt   = m_apt;
    exp_alarm = m_rct | m_apt;
    exp_ready = m_passed && !(m_rct || m_apt);
  endtask

  task automatic model_reset();
    hist.delete();
    m_rct = 0; m_apt = 0; m_passed = 0;
    exp_valid = 0; exp_r = 2'd0;
    model_publish();
  endtask

  task automatic model_step(input logic v, input logic [1:0] r, input logic clr);
    int n, run, start, cnt;
    bit ready_before, rct_hit, apt_hit;
    if (clr) begin
      hist.delete();
      m_rct = 0; m_apt = 0; m_passed = 0;
      exp_valid = 0;
    end else if (v) begin
      ready_before = m_passed && !(m_rct || m_apt);
      hist.push_back(r);
      n = hist.size();
      run = 0;
      for (int i = n - 1; i >= 0 && hist[i] == r; i--) run++;
      start = ((n - 1) / 64) * 64;
      cnt = 0;
      for (int i = start; i < n; i++) if (hist[i] == hist[start]) cnt++;
      rct_hit = (run >= 8);
      apt_hit = (cnt >= 40);
      m_rct = m_rct | rct_hit;
      m_apt = m_apt | apt_hit;
      exp_valid = ready_before && !rct_hit && !apt_hit;
      exp_r = r;
      if (n == 64 && !m_rct && !m_apt) m_passed = 1;
    end else begin
      exp_valid = 0;
    end
    model_publish();
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("cyc_o_valid", {7'd0, o_valid}, {7'd0, exp_valid});
      chk("cyc_o_r", {6'd0, o_r}, {6'd0, exp_r});
      chk("cyc_o_ready", {7'd0, o_ready}, {7'd0, exp_ready});
      chk("cyc_o_alarm", {7'd0, o_alarm}, {7'd0, exp_alarm});
      chk("cyc_o_rct_fail", {7'd0, o_rct_fail}, {7'd0, exp_rct});
      chk("cyc_o_apt_fail", {7'd0, o_apt_fail}, {7'd0, exp_apt});
    end
  end

  // Drive one cycle of inputs; returns just after the capturing edge.
  task automatic step(input logic v, input logic [1:0] r, input logic clr);
    @(negedge i_clk);
    #1;
    i_valid = v; i_r = r; i_clear = clr;
    model_step(v, r, clr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {7'd0, o_valid}, 8'd0);
    chk({tag, "_r"}, {6'd0, o_r}, 8'd0);
    chk({tag, "_ready"}, {7'd0, o_ready}, 8'd0);
    chk({tag, "_alarm"}, {7'd0, o_alarm}, 8'd0);
    chk({tag, "_rct"}, {7'd0, o_rct_fail}, 8'd0);
    chk({tag, "_apt"}, {7'd0, o_apt_fail}, 8'd0);
  endtask

  // 64 samples cycling 0..3 with idle gaps, then the first forwarded sample.
  task automatic run_startup(input string tag);
    logic [1:0] s;
    for (int i = 0; i < 64; i++) begin
      if (i % 16 == 5) step(1'b0, 2'd3, 1'b0);
      s = 2'(i % 4);
      step(1'b1, s, 1'b0);
      if (i == 62) chk({tag, "_ready_after63"}, {7'd0, o_ready}, 8'd0);
      if (i == 63) chk({tag, "_ready_after64"}, {7'd0, o_ready}, 8'd1);
    end
    chk({tag, "_no_rct"}, {7'd0, o_rct_fail}, 8'd0);
    chk({tag, "_no_apt"}, {7'd0, o_apt_fail}, 8'd0);
    step(1'b1, 2'd0, 1'b0);
    chk({tag, "_first_valid"}, {7'd0, o_valid}, 8'd1);
    chk({tag, "_first_r"}, {6'd0, o_r}, 8'd0);
  endtask

  initial begin
    logic [1:0] s;
    model_reset();
    repeat (2) @(negedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;
    chk_en = 1'b1;

    run_startup("startup1");

    // Eight repeats of 2'b01 while in RUN.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'd1, 1'b0);
      if (k == 6) chk("rct_7th_valid", {7'd0, o_valid}, 8'd1);
      if (k == 6) chk("rct_7th_no_fail", {7'd0, o_rct_fail}, 8'd0);
      if (k == 7) begin
        chk("rct_fail", {7'd0, o_rct_fail}, 8'd1);
        chk("rct_alarm", {7'd0, o_alarm}, 8'd1);
        chk("rct_8th_valid", {7'd0, o_valid}, 8'd0);
        chk("rct_ready", {7'd0, o_ready}, 8'd0);
      end
    end
    step(1'b1, 2'd2, 1'b0);

    // Clear with a concurrent sample that must not be counted.
    step(1'b1, 2'd1, 1'b1);
    chk("clr_alarm", {7'd0, o_alarm}, 8'd0);
    chk("clr_rct", {7'd0, o_rct_fail}, 8'd0);
    chk("clr_valid", {7'd0, o_valid}, 8'd0);
    run_startup("startup2");

    // Runs of seven 2'b10 broken by 2'b11 never trip the RCT.
    for (int j = 0; j < 80; j++) begin
      s = (j % 8 == 7) ? 2'd3 : 2'd2;
      step(1'b1, s, 1'b0);
    end
    chk("rct_seven_no_fail", {7'd0, o_rct_fail}, 8'd0);

    // APT: pattern 0,0,1 from a fresh window hits 40 zeros at index 58.
    step(1'b0, 2'd0, 1'b1);
    for (int j = 0; j < 63; j++) begin
      s = (j % 3 == 2) ? 2'd1 : 2'd0;
      step(1'b1, s, 1'b0);
      if (j == 57) chk("apt_idx57_no_fail", {7'd0, o_apt_fail}, 8'd0);
      if (j == 58) begin
        chk("apt_fail", {7'd0, o_apt_fail}, 8'd1);
        chk("apt_alarm", {7'd0, o_alarm}, 8'd1);
        chk("apt_no_rct", {7'd0, o_rct_fail}, 8'd0);
      end
    end
    chk("apt_never_ready", {7'd0, o_ready}, 8'd0);

    // Async reset mid-window with i_valid toggling.
    step(1'b0, 2'd0, 1'b1);
    for (int j = 0; j < 30; j++) begin
      s = 2'((j + 1) % 4);
      step(1'b1, s, 1'b0);
    end
    @(negedge i_clk);
    #2;
    i_valid = 1'b1;
    i_r = 2'd2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    for (int j = 0; j < 4; j++) begin
      @(negedge i_clk);
      #1;
      i_valid = ~i_valid;
    end
    @(negedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    run_startup("startup3");

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
